// File: rtl/rand_delay_pkg.sv
// Shared encodings for the random-delay transaction scheduler.
package rand_delay_pkg;

  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_FIXED = 2'd1;
  localparam logic [1:0] MODE_RAND  = 2'd2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  localparam logic [15:0] LFSR_POLY = 16'hB400;

endpackage

// File: rtl/rand_delay_lfsr.sv
// 16-bit right-shifting Galois LFSR with step enable; exposes the low byte used for delays.
module rand_delay_lfsr
  import rand_delay_pkg::*;
#(
  parameter logic [15:0] P_SEED = 16'hACE1
) (
  input  logic       clk_core,
  input  logic       rst_x,
  input  logic       i_step,
  output logic [7:0] o_state_lo
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);
  end

  always_ff @(posedge clk_core) begin
    if (rst_x) begin
      lfsr_q <= P_SEED;
    end else if (i_step) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign o_state_lo = lfsr_q[7:0];

endmodule

// File: rtl/rand_delay_sched.sv
// Single-slot scheduler: holds one transaction for a fixed or LFSR-driven delay, then presents it.
module rand_delay_sched
  import rand_delay_pkg::*;
#(
  parameter int unsigned P_WIDTH = 32,
  parameter int unsigned P_MIN   = 0,
  parameter logic [15:0] P_SEED  = 16'hACE1
) (
  input  logic               clk_core,
  input  logic               rst_x,
  input  logic [1:0]         i_mode,
  input  logic [7:0]         i_delay,
  input  logic [7:0]         i_mask,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [P_WIDTH-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [P_WIDTH-1:0] o_data,
  output logic               o_busy,
  output logic [15:0]        o_accept_cnt
);

  localparam logic [7:0] MinDelay = 8'(P_MIN);

  logic [1:0]         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [P_WIDTH-1:0] data_q, data_d;
  logic [15:0]        acc_cnt_q;
  logic [7:0]         lfsr_lo;
  logic [8:0]         rand_sum;
  logic [7:0]         delay;
  logic               accept;

  rand_delay_lfsr #(
    .P_SEED(P_SEED)
  ) u_lfsr (
    .clk_core  (clk_core),
    .rst_x     (rst_x),
    .i_step    (accept),
    .o_state_lo(lfsr_lo)
  );

  assign o_ready = (state_q == ST_IDLE) | ((state_q == ST_PRESENT) & i_ready);
  assign accept  = i_valid & o_ready;

  // Delay uses the pre-advance LFSR value; the sum saturates rather than wrapping.
  assign rand_sum = {1'b0, MinDelay} + {1'b0, lfsr_lo & i_mask};

  always_comb begin
    delay = 8'd0;
    case (i_mode)
      MODE_FIXED: delay = i_delay;
      MODE_RAND:  delay = rand_sum[8] ? 8'hFF : rand_sum[7:0];
      default:    delay = 8'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (i_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase
    // Accept overrides the drain so a presented slot can reload back-to-back.
    if (accept) begin
      data_d  = i_data;
      cnt_d   = delay;
      state_d = (delay == 8'd0) ? ST_PRESENT : ST_WAIT;
    end
  end

  always_ff @(posedge clk_core) begin
    if (rst_x) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      data_q    <= '0;
      acc_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      if (accept) begin
        acc_cnt_q <= acc_cnt_q + 16'd1;
      end
    end
  end

  assign o_valid      = (state_q == ST_PRESENT);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_data       = data_q;
  assign o_accept_cnt = acc_cnt_q;

endmodule

// File: tb/tb_rand_delay_sched.sv
// Randomized and directed checks of rand_delay_sched against a slot/timestamp reference model.
module tb_rand_delay_sched;

  localparam int W        = 32;
  localparam int MIN_MAIN = 2;

  logic          clk_core = 1'b0;
  logic          rst_x;
  logic [1:0]    i_mode;
  logic [7:0]    i_delay;
  logic [7:0]    i_mask;
  logic          i_valid;
  logic          i_ready;
  logic [W-1:0]  i_data;
  logic          o_ready, o_valid, o_busy;
  logic [W-1:0]  o_data;
  logic [15:0]   o_accept_cnt;
  logic          s_ready, s_valid, s_busy;
  logic [W-1:0]  s_data;
  logic [15:0]   s_accept_cnt;

  always #5 clk_core = ~clk_core;

  rand_delay_sched #(
    .P_WIDTH(W),
    .P_MIN  (MIN_MAIN),
    .P_SEED (16'hACE1)
  ) dut (
    .clk_core    (clk_core),
    .rst_x       (rst_x),
    .i_mode      (i_mode),
    .i_delay     (i_delay),
    .i_mask      (i_mask),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_busy      (o_busy),
    .o_accept_cnt(o_accept_cnt)
  );

  rand_delay_sched #(
    .P_WIDTH(W),
    .P_MIN  (250),
    .P_SEED (16'hACE1)
  ) dut_sat (
    .clk_core    (clk_core),
    .rst_x       (rst_x),
    .i_mode      (i_mode),
    .i_delay     (i_delay),
    .i_mask      (i_mask),
    .i_valid     (i_valid),
    .o_ready     (s_ready),
    .i_data      (i_data),
    .o_valid     (s_valid),
    .i_ready     (i_ready),
    .o_data      (s_data),
    .o_busy      (s_busy),
    .o_accept_cnt(s_accept_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an occupied flag plus the cycle at which the held item becomes visible.
  int          cyc;
  bit          m_full;
  int          m_rdy;
  logic [31:0] m_data;
  logic [15:0] m_cnt;
  logic [15:0] m_lfsr;
  int          rise_main, rise_sat;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic int delay_of(input int pmin, input logic [1:0] mode, input logic [7:0] dly,
                                  input logic [7:0] mask, input logic [15:0] lfsr);
    int v;
    if (mode == 2'd1) return int'(dly);
    if (mode == 2'd2) begin
      v = pmin + int'(lfsr[7:0] & mask);
      return (v > 255) ? 255 : v;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_full = 0;
    m_rdy  = 0;
    m_data = '0;
    m_cnt  = '0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic arm();
    rise_main = -1;
    rise_sat  = -1;
  endtask

  task automatic cycle();
    bit ev, er, acc;
    @(negedge clk_core);
    ev = m_full && (cyc >= m_rdy);
    er = !m_full || (ev && i_ready);
    check_eq("o_valid", {31'd0, o_valid}, {31'd0, ev});
    check_eq("o_ready", {31'd0, o_ready}, {31'd0, er});
    check_eq("o_busy", {31'd0, o_busy}, {31'd0, m_full});
    check_eq("o_data", o_data, m_data);
    check_eq("o_accept_cnt", {16'd0, o_accept_cnt}, {16'd0, m_cnt});
    if (o_valid === 1'b1 && rise_main < 0) rise_main = cyc;
    if (s_valid === 1'b1 && rise_sat < 0) rise_sat = cyc;
    acc = i_valid && er;
    if (rst_x) begin
      model_reset();
    end else if (acc) begin
      m_full = 1;
      m_rdy  = cyc + 1 + delay_of(MIN_MAIN, i_mode, i_delay, i_mask, m_lfsr);
      m_data = i_data;
      m_cnt  = m_cnt + 16'd1;
      m_lfsr = lfsr_next(m_lfsr);
    end else if (ev && i_ready) begin
      m_full = 0;
    end
    @(posedge clk_core);
    #1;
    cyc++;
  endtask

  task automatic pulse_reset();
    rst_x = 1'b1;
    cycle();
    rst_x = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    int t;
    rst_x = 1'b1; i_mode = 2'd0; i_delay = 8'd0; i_mask = 8'd0;
    i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
    cyc = 0;
    arm();
    model_reset();
    repeat (2) @(posedge clk_core);
    #1;
    cycle();
    rst_x = 1'b0;
    idle_cycles(2);

    // Pass mode streaming at full rate.
    i_mode = 2'd0; i_ready = 1'b1; i_valid = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      i_data = k;
      cycle();
    end
    i_valid = 1'b0;
    idle_cycles(2);
    check_eq("stream_count", {16'd0, o_accept_cnt}, 32'd20);

    // Fixed delay 5, downstream stalled until presented.
    i_mode = 2'd1; i_delay = 8'd5; i_ready = 1'b0;
    t = cyc; arm();
    i_valid = 1'b1; i_data = 32'h55;
    cycle();
    i_valid = 1'b0;
    idle_cycles(10);
    check_eq("fixed5_latency", rise_main - t, 32'd6);
    i_ready = 1'b1;
    idle_cycles(2);

    // Random mode from seed: delays 3 then 2.
    pulse_reset();
    i_mode = 2'd2; i_mask = 8'h0F; i_ready = 1'b1;
    t = cyc; arm();
    i_valid = 1'b1; i_data = 32'hAA01;
    cycle();
    i_valid = 1'b0;
    idle_cycles(8);
    check_eq("rand_first_latency", rise_main - t, 32'd4);
    t = cyc; arm();
    i_valid = 1'b1; i_data = 32'hAA02;
    cycle();
    i_valid = 1'b0;
    idle_cycles(8);
    check_eq("rand_second_latency", rise_main - t, 32'd3);

    // Downstream stall in PRESENT, then back-to-back accept on release.
    i_mode = 2'd0; i_valid = 1'b1; i_data = 32'hA0; i_ready = 1'b1;
    cycle();
    i_ready = 1'b0; i_data = 32'hA1;
    idle_cycles(10);
    check_eq("stall_data", o_data, 32'hA0);
    i_ready = 1'b1;
    cycle();
    i_valid = 1'b0;
    idle_cycles(3);
    check_eq("stall_b2b_data", o_data, 32'hA1);

    // Reset while waiting drops the item and reloads the LFSR.
    i_mode = 2'd1; i_delay = 8'd20; i_valid = 1'b1; i_data = 32'hBEEF;
    cycle();
    i_valid = 1'b0;
    idle_cycles(3);
    pulse_reset();
    cycle();
    check_eq("rst_wait_acnt", {16'd0, o_accept_cnt}, 32'd0);
    i_mode = 2'd2; i_mask = 8'h0F;
    t = cyc; arm();
    i_valid = 1'b1; i_data = 32'hC0;
    cycle();
    i_valid = 1'b0;
    idle_cycles(8);
    check_eq("rst_reseed_latency", rise_main - t, 32'd4);

    // Saturation: P_MIN 250 + 0xE1 clamps to 255.
    pulse_reset();
    i_mode = 2'd2; i_mask = 8'hFF; i_ready = 1'b0;
    t = cyc; arm();
    i_valid = 1'b1; i_data = 32'hD0;
    cycle();
    i_valid = 1'b0;
    idle_cycles(270);
    check_eq("sat_latency", rise_sat - t, 32'd256);
    check_eq("sat_main_latency", rise_main - t, 32'd228);
    i_ready = 1'b1;
    idle_cycles(2);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rst_x   = ($urandom_range(0, 299) == 0);
      i_mode  = 2'($urandom_range(0, 3));
      i_delay = 8'($urandom_range(0, 6));
      i_mask  = 8'($urandom & 32'h1F);
      i_valid = ($urandom_range(0, 9) < 7);
      i_ready = ($urandom_range(0, 9) < 6);
      i_data  = $urandom;
      cycle();
    end
    rst_x = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    idle_cycles(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
